// File: rtl/qconv_khw_loop_if.sv
// Kernel-buffer read-request bus: valid/ready handshake carrying the address
// and the kh/kw/ic_high loop indices of the current point.
interface qconv_khw_loop_if #(
    parameter int KhBitWidth     = 2,
    parameter int KwBitWidth     = 2,
    parameter int IcHighBitWidth = 4,
    parameter int AddrWidth      = 16
);
    logic                      req_valid;
    logic                      req_ready;
    logic [AddrWidth-1:0]      req_addr;
    logic [KhBitWidth-1:0]     req_kh;
    logic [KwBitWidth-1:0]     req_kw;
    logic [IcHighBitWidth-1:0] req_ic_high;
    logic                      req_last;

    modport master (
        output req_valid, req_addr, req_kh, req_kw, req_ic_high, req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_kh, req_kw, req_ic_high, req_last,
        output req_ready
    );
endinterface

// File: rtl/qconv_khw_loop.sv
// Kernel-height/width loop engine: on a start pulse it walks kh x kw x ic_high,
// issues one kernel-buffer read per point and answers with a one-cycle finish.
module qconv_khw_loop #(
    parameter int KhBitWidth     = 2,
    parameter int KwBitWidth     = 2,
    parameter int IcHighBitWidth = 4,
    parameter int AddrWidth      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [KhBitWidth-1:0]     kh_num,
    input  logic [KwBitWidth-1:0]     kw_num,
    input  logic [IcHighBitWidth-1:0] ic_high_num,
    input  logic [AddrWidth-1:0]      base_addr,
    qconv_khw_loop_if.master          bus,
    output logic                      busy,
    output logic                      finish
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

    state_e                    state_q, state_d;
    logic [KhBitWidth-1:0]     kh_num_q, kh_num_d, kh_q, kh_d;
    logic [KwBitWidth-1:0]     kw_num_q, kw_num_d, kw_q, kw_d;
    logic [IcHighBitWidth-1:0] ich_num_q, ich_num_d, ich_q, ich_d;
    logic [AddrWidth-1:0]      addr_q, addr_d;
    logic                      finish_q, finish_d;

    logic kh_end, kw_end, ich_end, is_last, fire;

    assign kh_end  = (kh_q  == kh_num_q  - KhBitWidth'(1));
    assign kw_end  = (kw_q  == kw_num_q  - KwBitWidth'(1));
    assign ich_end = (ich_q == ich_num_q - IcHighBitWidth'(1));
    assign is_last = (state_q == ISSUE) && kh_end && kw_end && ich_end;
    assign fire    = (state_q == ISSUE) && bus.req_ready;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d   = state_q;
        kh_num_d  = kh_num_q;
        kw_num_d  = kw_num_q;
        ich_num_d = ich_num_q;
        kh_d      = kh_q;
        kw_d      = kw_q;
        ich_d     = ich_q;
        addr_d    = addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    kh_num_d  = kh_num;
                    kw_num_d  = kw_num;
                    ich_num_d = ic_high_num;
                    addr_d    = base_addr;
                    kh_d      = '0;
                    kw_d      = '0;
                    ich_d     = '0;
                    if (kh_num == '0 || kw_num == '0 || ic_high_num == '0) state_d = DONE;
                    else                                                  state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (fire) begin
                    addr_d = addr_q + AddrWidth'(1);
                    // ic_high is the innermost loop, then kw, then kh.
                    if (ich_end) begin
                        ich_d = '0;
                        if (kw_end) begin
                            kw_d = '0;
                            kh_d = kh_q + KhBitWidth'(1);
                        end else begin
                            kw_d = kw_q + KwBitWidth'(1);
                        end
                    end else begin
                        ich_d = ich_q + IcHighBitWidth'(1);
                    end
                    if (is_last) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        finish_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            kh_num_q  <= '0;
            kw_num_q  <= '0;
            ich_num_q <= '0;
            kh_q      <= '0;
            kw_q      <= '0;
            ich_q     <= '0;
            addr_q    <= '0;
            finish_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            kh_num_q  <= kh_num_d;
            kw_num_q  <= kw_num_d;
            ich_num_q <= ich_num_d;
            kh_q      <= kh_d;
            kw_q      <= kw_d;
            ich_q     <= ich_d;
            addr_q    <= addr_d;
            finish_q  <= finish_d;
        end
    end

    assign bus.req_valid   = (state_q == ISSUE);
    assign bus.req_addr    = addr_q;
    assign bus.req_kh      = kh_q;
    assign bus.req_kw      = kw_q;
    assign bus.req_ic_high = ich_q;
    assign bus.req_last    = is_last;
    assign busy            = (state_q != IDLE);
    assign finish          = finish_q;

endmodule

// File: tb/tb_qconv_khw_loop.sv
// Self-checking bench for qconv_khw_loop: table of loop configurations checked
// against a queue of expected request beats, plus a mid-loop reset sequence.
module tb_qconv_khw_loop;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  kh_num, kw_num;
    logic [3:0]  ic_high_num;
    logic [15:0] base_addr;
    logic        busy, finish;

    qconv_khw_loop_if #(.KhBitWidth(2), .KwBitWidth(2), .IcHighBitWidth(4), .AddrWidth(16)) bus ();

    qconv_khw_loop #(.KhBitWidth(2), .KwBitWidth(2), .IcHighBitWidth(4), .AddrWidth(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .kh_num      (kh_num),
        .kw_num      (kw_num),
        .ic_high_num (ic_high_num),
        .base_addr   (base_addr),
        .bus         (bus),
        .busy        (busy),
        .finish      (finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kh;
        logic [1:0]  kw;
        logic [3:0]  ich;
        logic [15:0] base;
        bit          toggle;
        bit          perturb;
        int          exp_n;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  kh;
        logic [1:0]  kw;
        logic [3:0]  ich;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_cfg(input vec_t v);
        int    n;
        int    k      = 0;
        int    fin_k  = -1;
        int    fin_obs = -1;
        int    fires  = 0;
        int    budget;
        bit    done   = 0;
        bit    exp_busy;
        beat_t b;

        exp_q.delete();
        n = int'(v.kh) * int'(v.kw) * int'(v.ich);
        for (int i = 0; i < int'(v.kh); i++)
            for (int j = 0; j < int'(v.kw); j++)
                for (int c = 0; c < int'(v.ich); c++) begin
                    b.addr = v.base + 16'(exp_q.size());
                    b.kh   = 2'(i);
                    b.kw   = 2'(j);
                    b.ich  = 4'(c);
                    b.last = (exp_q.size() == n - 1);
                    exp_q.push_back(b);
                end
        if (n == 0) fin_k = 1;
        budget = 4 * n + 10;

        @(posedge clk); #1;
        start       = 1'b1;
        kh_num      = v.kh;
        kw_num      = v.kw;
        ic_high_num = v.ich;
        base_addr   = v.base;

        while (!done && k < budget) begin
            @(posedge clk); #1;
            k++;
            start = 1'b0;
            if (v.perturb && k == 3) begin
                start       = 1'b1;
                kh_num      = 2'd1;
                kw_num      = 2'd1;
                ic_high_num = 4'd1;
                base_addr   = 16'hAAAA;
            end else if (v.perturb && k == 5) begin
                kh_num = 2'd0;
            end
            bus.req_ready = v.toggle ? ((k % 2) == 1) : 1'b1;

            @(negedge clk);
            exp_busy = (exp_q.size() > 0) || (k == fin_k);
            check("req_valid", 32'(bus.req_valid), 32'(exp_q.size() > 0));
            if (bus.req_valid && exp_q.size() > 0) begin
                check("req_addr",    32'(bus.req_addr),    32'(exp_q[0].addr));
                check("req_kh",      32'(bus.req_kh),      32'(exp_q[0].kh));
                check("req_kw",      32'(bus.req_kw),      32'(exp_q[0].kw));
                check("req_ic_high", 32'(bus.req_ic_high), 32'(exp_q[0].ich));
                check("req_last",    32'(bus.req_last),    32'(exp_q[0].last));
                if (bus.req_ready) begin
                    void'(exp_q.pop_front());
                    fires++;
                    if (exp_q.size() == 0) fin_k = k + 1;
                end
            end
            check("finish", 32'(finish), 32'(k == fin_k));
            check("busy",   32'(busy),   32'(exp_busy));
            if (finish) fin_obs = k;
            if (k == fin_k) done = 1;
        end
        if (!done) check("timeout", 32'(0), 32'(1));

        check("beat_count", 32'(fires), 32'(v.exp_n));
        if (!v.toggle) check("finish_latency", 32'(fin_obs), 32'(v.exp_n + 1));

        // finish must be a single-cycle pulse and the block back in IDLE
        @(posedge clk); #1;
        bus.req_ready = 1'b0;
        @(negedge clk);
        check("finish_single", 32'(finish),        32'(0));
        check("busy_after",    32'(busy),          32'(0));
        check("valid_after",   32'(bus.req_valid), 32'(0));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{kh: 2'd3, kw: 2'd3, ich: 4'd2, base: 16'h0010, toggle: 0, perturb: 0, exp_n: 18};
        vecs[1] = '{kh: 2'd3, kw: 2'd3, ich: 4'd2, base: 16'h0010, toggle: 1, perturb: 0, exp_n: 18};
        vecs[2] = '{kh: 2'd0, kw: 2'd2, ich: 4'd3, base: 16'h0100, toggle: 0, perturb: 0, exp_n: 0};
        vecs[3] = '{kh: 2'd1, kw: 2'd1, ich: 4'd4, base: 16'hFFFE, toggle: 0, perturb: 0, exp_n: 4};
        vecs[4] = '{kh: 2'd3, kw: 2'd3, ich: 4'd2, base: 16'h0010, toggle: 0, perturb: 1, exp_n: 18};
        vecs[5] = '{kh: 2'd2, kw: 2'd3, ich: 4'd1, base: 16'h8000, toggle: 1, perturb: 0, exp_n: 6};

        rst_n         = 1'b0;
        start         = 1'b0;
        kh_num        = '0;
        kw_num        = '0;
        ic_high_num   = '0;
        base_addr     = '0;
        bus.req_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid",  32'(bus.req_valid), 32'(0));
        check("rst_busy",   32'(busy),          32'(0));
        check("rst_finish", 32'(finish),        32'(0));
        check("rst_addr",   32'(bus.req_addr),  32'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_cfg(vecs[i]);

        // Asynchronous reset while request 5 of 18 is on the bus
        @(posedge clk); #1;
        start       = 1'b1;
        kh_num      = 2'd3;
        kw_num      = 2'd3;
        ic_high_num = 4'd2;
        base_addr   = 16'h0010;
        bus.req_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_rst_addr",  32'(bus.req_addr),  32'h0014);
        check("pre_rst_valid", 32'(bus.req_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        check("arst_valid",  32'(bus.req_valid),   32'(0));
        check("arst_last",   32'(bus.req_last),    32'(0));
        check("arst_busy",   32'(busy),            32'(0));
        check("arst_finish", 32'(finish),          32'(0));
        check("arst_addr",   32'(bus.req_addr),    32'(0));
        check("arst_kw",     32'(bus.req_kw),      32'(0));
        check("arst_ich",    32'(bus.req_ic_high), 32'(0));
        repeat (3) begin
            @(negedge clk);
            check("arst_no_finish", 32'(finish), 32'(0));
        end
        rst_n = 1'b1;
        bus.req_ready = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'(0));

        run_cfg(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
